tff_updown_counter: RTL and testbench

- Parametrised successor to the single-bit T flip-flop: a WIDTH-bit bank of T flip-flops, sequenced as a loadable up/down counter.
- Each state bit is a T flip-flop. Per-bit toggle enables are derived from the required next value: t_i = q_i XOR next_i.
- Supports a programmable modulus (MAX_VAL), wrap or saturate mode, synchronous clear/load, and terminal-count/wrap flags.
- Used as a general event/decade counter and as a clock-divider building block.

---
 rtl/tff_updown_counter.sv | 71 +++++++
 tb/tb_tff_updown_counter.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/tff_updown_counter.sv
// WIDTH-bit bank of T flip-flops sequenced as a loadable up/down counter
// with programmable modulus, wrap/saturate limits and terminal-count flags.
module tff_updown_counter #(
  parameter int WIDTH    = 4,
  parameter int MAX_VAL  = 2**WIDTH - 1,
  parameter bit SATURATE = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             load,
  input  logic [WIDTH-1:0] din,
  input  logic             en,
  input  logic             up,
  output logic [WIDTH-1:0] q,
  output logic             tc,
  output logic             wrap,
  output logic [WIDTH-1:0] toggles
);

  localparam logic [WIDTH-1:0] MAX_Q = WIDTH'(MAX_VAL);
  localparam logic [WIDTH-1:0] ONE   = WIDTH'(1);

  logic [WIDTH-1:0] next_q;
  logic             at_max;
  logic             at_min;
  logic             limit;

  assign at_max = (q == MAX_Q);
  assign at_min = (q == '0);

  // Required next value; the state bits only ever see it as a toggle mask.
  always_comb begin
    // NOTE: every output of this block gets a default first so no path
    // leaves it unassigned, which would otherwise infer a latch.
    next_q = q;
    limit  = 1'b0;
    if (clr) begin
      next_q = '0;
    end else if (load) begin
      next_q = (din > MAX_Q) ? MAX_Q : din;
    end else if (en) begin
      if (up) begin
        limit = at_max;
        if (!at_max)       next_q = q + ONE;
        else if (!SATURATE) next_q = '0;
      end else begin
        limit = at_min;
        if (!at_min)       next_q = q - ONE;
        else if (!SATURATE) next_q = MAX_Q;
      end
    end
  end

  // Flags are forced low while reset holds the bank at zero.
  assign tc      = limit & ~rst;
  assign toggles = rst ? '0 : (q ^ next_q);

  always_ff @(posedge clk or posedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    if (rst) begin
      q    <= '0;
      wrap <= 1'b0;
    end else begin
      q    <= q ^ toggles;
      wrap <= tc;
    end
  end

endmodule

// File: tb/tb_tff_updown_counter.sv
// Self-checking bench: a decade wrapping counter and a 4-bit saturating
// counter share stimulus and are compared against an arithmetic model.
module tb_tff_updown_counter;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       clr = 1'b0;
  logic       load = 1'b0;
  logic [3:0] din = '0;
  logic       en = 1'b0;
  logic       up = 1'b1;

  logic [3:0] dq   [2];
  logic [3:0] dtog [2];
  logic       dtc  [2];
  logic       dwrap[2];

  int n_cmp = 0;
  int n_bad = 0;

  int m_q   [2];
  int m_wrap[2];
  int mx    [2] = '{9, 15};
  bit sat   [2] = '{1'b0, 1'b1};

  always #5 clk = ~clk;

  tff_updown_counter #(.WIDTH(4), .MAX_VAL(9), .SATURATE(1'b0)) dut_dec (
    .clk(clk), .rst(rst), .clr(clr), .load(load), .din(din), .en(en), .up(up),
    .q(dq[0]), .tc(dtc[0]), .wrap(dwrap[0]), .toggles(dtog[0])
  );

  tff_updown_counter #(.WIDTH(4), .MAX_VAL(15), .SATURATE(1'b1)) dut_sat (
    .clk(clk), .rst(rst), .clr(clr), .load(load), .din(din), .en(en), .up(up),
    .q(dq[1]), .tc(dtc[1]), .wrap(dwrap[1]), .toggles(dtog[1])
  );

  // Reference: the counting rules stated directly with integer arithmetic.
  function automatic int model_next(int cur, int lim, bit s, bit c, bit l, int d, bit e, bit u);
    if (c) return 0;
    if (l) return (d > lim) ? lim : d;
    if (!e) return cur;
    if (u) return (cur == lim) ? (s ? cur : 0) : cur + 1;
    return (cur == 0) ? (s ? 0 : lim) : cur - 1;
  endfunction

  function automatic bit model_tc(int cur, int lim, bit c, bit l, bit e, bit u);
    return e && !c && !l && (u ? (cur == lim) : (cur == 0));
  endfunction

  // One clock: drive, check combinational outputs, clock, check registers.
  task automatic cycle(input string name, input bit c, input bit l, input logic [3:0] d,
                       input bit e, input bit u);
    int nq[2];
    bit et[2];
    clr = c; load = l; din = d; en = e; up = u;
    #1;
    for (int i = 0; i < 2; i++) begin
      nq[i] = model_next(m_q[i], mx[i], sat[i], c, l, int'(d), e, u);
      et[i] = model_tc(m_q[i], mx[i], c, l, e, u);
      n_cmp++;
      if (dtc[i] !== et[i]) begin
        n_bad++;
        $display("FAIL %s inst%0d tc: got %b expected %b", name, i, dtc[i], et[i]);
      end
      n_cmp++;
      if (dtog[i] !== 4'(m_q[i] ^ nq[i])) begin
        n_bad++;
        $display("FAIL %s inst%0d toggles: got %b expected %b", name, i, dtog[i], 4'(m_q[i] ^ nq[i]));
      end
    end
    @(posedge clk);
    for (int i = 0; i < 2; i++) begin
      m_q[i]    = nq[i];
      m_wrap[i] = int'(et[i]);
    end
    #1;
    for (int i = 0; i < 2; i++) begin
      n_cmp++;
      if (dq[i] !== 4'(m_q[i])) begin
        n_bad++;
        $display("FAIL %s inst%0d q: got %0d expected %0d", name, i, dq[i], m_q[i]);
      end
      n_cmp++;
      if (dwrap[i] !== 1'(m_wrap[i])) begin
        n_bad++;
        $display("FAIL %s inst%0d wrap: got %b expected %0d", name, i, dwrap[i], m_wrap[i]);
      end
    end
  endtask

  task automatic expect_q(input string name, input int i, input int exp_q);
    n_cmp++;
    if (dq[i] !== 4'(exp_q)) begin
      n_bad++;
      $display("FAIL %s inst%0d q: got %0d expected %0d", name, i, dq[i], exp_q);
    end
  endtask

  task automatic expect_reset_state(input string name);
    for (int i = 0; i < 2; i++) begin
      n_cmp++;
      if (dq[i] !== 4'd0 || dwrap[i] !== 1'b0 || dtc[i] !== 1'b0 || dtog[i] !== 4'd0) begin
        n_bad++;
        $display("FAIL %s inst%0d: got q=%0d wrap=%b tc=%b toggles=%b expected all zero",
                 name, i, dq[i], dwrap[i], dtc[i], dtog[i]);
      end
    end
  endtask

  task automatic test_reset();
    en = 1'b1; up = 1'b1;
    #1;
    expect_reset_state("reset_initial");
    repeat (2) @(posedge clk);
    #1;
    expect_reset_state("reset_held");
    @(negedge clk);
    rst = 1'b0;
    m_q = '{0, 0};
    m_wrap = '{0, 0};
  endtask

  task automatic test_decade();
    int seq[12] = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 0, 1, 2};
    for (int k = 0; k < 12; k++) begin
      cycle("decade_up", 1'b0, 1'b0, 4'd0, 1'b1, 1'b1);
      expect_q("decade_seq", 0, seq[k]);
      if (k == 9) begin
        n_cmp++;
        if (dwrap[0] !== 1'b1) begin
          n_bad++;
          $display("FAIL decade_wrap_at_0: got %b expected 1", dwrap[0]);
        end
      end
    end
  endtask

  task automatic test_down_wrap();
    int seq[3] = '{0, 9, 8};
    cycle("down_load", 1'b0, 1'b1, 4'd1, 1'b0, 1'b0);
    expect_q("down_load", 0, 1);
    for (int k = 0; k < 3; k++) begin
      cycle("down_count", 1'b0, 1'b0, 4'd0, 1'b1, 1'b0);
      expect_q("down_seq", 0, seq[k]);
    end
  endtask

  task automatic test_saturate();
    cycle("sat_load", 1'b0, 1'b1, 4'd14, 1'b0, 1'b1);
    expect_q("sat_load", 1, 14);
    for (int k = 0; k < 4; k++) begin
      cycle("sat_up", 1'b0, 1'b0, 4'd0, 1'b1, 1'b1);
      expect_q("sat_hold", 1, 15);
      n_cmp++;
      if (dwrap[1] !== (k > 0)) begin
        n_bad++;
        $display("FAIL sat_wrap step%0d: got %b expected %b", k, dwrap[1], (k > 0));
      end
    end
    cycle("sat_down", 1'b0, 1'b0, 4'd0, 1'b1, 1'b0);
    expect_q("sat_down", 1, 14);
  endtask

  task automatic test_priority();
    cycle("prio_clr_load", 1'b1, 1'b1, 4'd5, 1'b1, 1'b1);
    expect_q("prio_clr", 0, 0);
    cycle("prio_load_clamp", 1'b0, 1'b1, 4'd12, 1'b1, 1'b1);
    expect_q("prio_clamp", 0, 9);
    expect_q("prio_noclamp", 1, 12);
  endtask

  task automatic test_async_reset();
    cycle("async_clr", 1'b1, 1'b0, 4'd0, 1'b0, 1'b1);
    for (int k = 0; k < 6; k++) cycle("async_count", 1'b0, 1'b0, 4'd0, 1'b1, 1'b1);
    expect_q("async_pre", 0, 6);
    clr = 1'b0; load = 1'b0; en = 1'b0;
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    expect_reset_state("async_mid_cycle");
    en = 1'b1; up = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    expect_reset_state("async_hold");
    @(negedge clk);
    rst = 1'b0;
    m_q = '{0, 0};
    m_wrap = '{0, 0};
    cycle("async_release", 1'b0, 1'b0, 4'd0, 1'b1, 1'b1);
    expect_q("async_first_inc", 0, 1);
  endtask

  task automatic test_hold_flip();
    int seq[4] = '{5, 4, 5, 4};
    cycle("hold_clr", 1'b1, 1'b0, 4'd0, 1'b0, 1'b1);
    for (int k = 0; k < 4; k++) cycle("hold_count", 1'b0, 1'b0, 4'd0, 1'b1, 1'b1);
    for (int k = 0; k < 3; k++) begin
      cycle("hold", 1'b0, 1'b0, 4'd0, 1'b0, k[0]);
      expect_q("hold_q", 0, 4);
    end
    for (int k = 0; k < 4; k++) begin
      cycle("flip", 1'b0, 1'b0, 4'd0, 1'b1, (k % 2) == 0);
      expect_q("flip_seq", 0, seq[k]);
    end
  endtask

  task automatic test_random();
    for (int k = 0; k < 400; k++) begin
      cycle("random", ($urandom_range(0, 19) == 0), ($urandom_range(0, 9) == 0),
            4'($urandom_range(0, 15)), ($urandom_range(0, 3) != 0), $urandom_range(0, 1) == 1);
    end
  endtask

  task automatic test_back_to_back();
    cycle("b2b_load", 1'b0, 1'b1, 4'd0, 1'b0, 1'b0);
    for (int k = 0; k < 5; k++) cycle("b2b_down_limit", 1'b0, 1'b0, 4'd0, 1'b1, 1'b0);
    for (int k = 0; k < 20; k++) cycle("b2b_up", 1'b0, 1'b0, 4'd0, 1'b1, 1'b1);
  endtask

  initial begin
    test_reset();
    test_decade();
    test_down_wrap();
    test_saturate();
    test_priority();
    test_async_reset();
    test_hold_flip();
    test_back_to_back();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
